// File: rtl/tx_filt_ctrl.sv
// Symbol upsampler feeding the TX pulse-shaping filter, with a double-buffered coefficient bank.
// x_out is registered one edge after acceptance; sym_ready drops while the one-entry buffer holds a symbol.
module tx_filt_ctrl #(
    parameter int OSR       = 4,
    parameter int NUM_COEF  = 11,
    parameter int FLUSH_LEN = 21
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [17:0]            sym_in,
    input  logic                   sym_valid,
    output logic                   sym_ready,
    input  logic                   coef_wr,
    input  logic [3:0]             coef_addr,
    input  logic [17:0]            coef_data,
    input  logic                   coef_commit,
    output logic                   coef_busy,
    output logic                   coef_err,
    output logic [18*NUM_COEF-1:0] coef_active,
    output logic [17:0]            x_out,
    output logic                   active,
    output logic                   underflow
);

    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);
    localparam logic [FW-1:0] FL_LAST = FW'(FLUSH_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    function automatic logic [17:0] coef_default(input int k);
        case (k)
            0:       return 18'(299);
            1:       return 18'(613);
            2:       return 18'(414);
            3:       return 18'(-786);
            4:       return 18'(-2608);
            5:       return 18'(-3424);
            6:       return 18'(-1082);
            7:       return 18'(5451);
            8:       return 18'(14715);
            9:       return 18'(22988);
            10:      return 18'(26311);
            default: return 18'd0;
        endcase
    endfunction

    logic [1:0]    state;
    logic [PW-1:0] ph;
    logic [FW-1:0] fcnt;
    logic [17:0]   sym_buf;
    logic          buf_full;
    logic          ph_last;
    logic [PW-1:0] ph_inc;
    logic          xfer;

    assign ph_last   = (ph == PH_LAST);
    assign ph_inc    = ph_last ? '0 : ph + 1'b1;
    assign sym_ready = !buf_full || (ph_last && (state == S_RUN));
    assign xfer      = sym_valid && sym_ready;
    assign active    = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ph        <= '0;
            fcnt      <= '0;
            sym_buf   <= '0;
            buf_full  <= 1'b0;
            x_out     <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= 1'b0;
            x_out     <= '0;
            case (state)
                S_IDLE: begin
                    // First symbol bypasses the buffer; ph stays 0 so the next
                    // symbol lands exactly OSR samples later.
                    ph <= '0;
                    if (xfer) begin
                        x_out <= sym_in;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    ph <= ph_inc;
                    if (ph_last) begin
                        if (buf_full) begin
                            x_out    <= sym_buf;
                            buf_full <= xfer;
                        end else begin
                            underflow <= 1'b1;
                            state     <= S_FLUSH;
                            fcnt      <= '0;
                            buf_full  <= xfer;
                        end
                        if (xfer) sym_buf <= sym_in;
                    end else if (xfer) begin
                        sym_buf  <= sym_in;
                        buf_full <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    ph <= ph_inc;
                    if (xfer) begin
                        sym_buf  <= sym_in;
                        buf_full <= 1'b1;
                    end
                    // A pending symbol holds off the return to IDLE until its slot.
                    if (ph_last && buf_full) begin
                        x_out    <= sym_buf;
                        buf_full <= 1'b0;
                        state    <= S_RUN;
                        fcnt     <= '0;
                    end else if (fcnt == FL_LAST) begin
                        if (!buf_full && !xfer) begin
                            state <= S_IDLE;
                            ph    <= '0;
                        end
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ph    <= '0;
                end
            endcase
        end
    end

    logic [17:0] shadow   [NUM_COEF];
    logic [17:0] act_bank [NUM_COEF];
    logic        wr_ok;
    logic        swap;

    assign wr_ok = coef_wr && !coef_busy && ({1'b0, coef_addr} < 5'(NUM_COEF));
    assign swap  = coef_busy && ((state == S_IDLE) || ph_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_COEF; k++) begin
                shadow[k]   <= coef_default(k);
                act_bank[k] <= coef_default(k);
            end
            coef_busy <= 1'b0;
            coef_err  <= 1'b0;
        end else begin
            coef_err <= coef_wr && !wr_ok;
            if (wr_ok) shadow[coef_addr] <= coef_data;
            if (swap) begin
                for (int k = 0; k < NUM_COEF; k++) act_bank[k] <= shadow[k];
                coef_busy <= 1'b0;
            end else if (coef_commit) begin
                coef_busy <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_COEF; g++) begin : g_flat
        assign coef_active[18*g +: 18] = act_bank[g];
    end

endmodule
